// File: rtl/dehaze_pkg.sv
// Shared types and constants for the dehaze frame controller: FSM encoding,
// the haze-weight table and the default transmittance floor.
package dehaze_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [7:0] T0_DEFAULT = 8'd26;

  // Entry i covers frame maxima up to LUT_UPPER[i] (inclusive), above LUT_UPPER[i-1].
  localparam int LUT_N = 10;
  localparam logic [LUT_N-1:0][7:0] LUT_UPPER = {
    8'd255, 8'd240, 8'd230, 8'd220, 8'd210,
    8'd200, 8'd190, 8'd180, 8'd170, 8'd160
  };
  localparam logic [LUT_N-1:0][7:0] LUT_WEIGHT = {
    8'd164, 8'd176, 8'd184, 8'd192, 8'd200,
    8'd208, 8'd224, 8'd240, 8'd255, 8'd0
  };

endpackage

// File: rtl/dehaze_weight_lut.sv
// Maps a frame's dark-channel maximum to the haze weight (w*256).
// Purely combinational range lookup over the package breakpoints.
module dehaze_weight_lut
  import dehaze_pkg::*;
(
  input  logic [7:0] dark_max,
  output logic [7:0] weight
);

  logic [3:0] idx;

  // Scan from the top entry down so the lowest matching range wins.
  always_comb begin
    // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
    idx    = '0;
    weight = LUT_WEIGHT[4'(LUT_N-1)];
    for (int i = LUT_N - 1; i >= 0; i--) begin
      idx = 4'(i);
      if (dark_max <= LUT_UPPER[idx]) weight = LUT_WEIGHT[idx];
    end
  end

endmodule

// File: rtl/dehaze_frame_ctrl.sv
// Per-frame control for the dehaze datapath: tracks the dark-channel maximum,
// publishes atmospheric light and haze weight at frame boundaries, detects loss of video.
module dehaze_frame_ctrl
  import dehaze_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215,
  parameter logic [7:0]  T0             = T0_DEFAULT
) (
  input  logic       pixelclk,
  input  logic       reset_n,
  input  logic [7:0] i_dark,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_de,
  input  logic       i_cfg_w_manual_en,
  input  logic [7:0] i_cfg_w_manual,
  input  logic       i_cfg_freeze,
  output logic [7:0] o_dark_max,
  output logic [7:0] o_weight,
  output logic [7:0] o_t_floor,
  output logic       o_param_valid,
  output logic       o_frame_done,
  output logic       o_timeout,
  output logic [1:0] o_state
);

  state_t      state;
  logic [7:0]  dark_s1;
  logic        de_s1;
  logic        vsync_s1;
  logic        vsync_s1_q;
  logic [7:0]  run_max;
  logic [7:0]  restart_max;
  logic [23:0] tmo_cnt;
  logic        frame_start;
  logic        tmo_hit;
  logic [7:0]  table_weight;
  logic        unused_hsync;

  // Row timing has no bearing on a frame-wide maximum.
  assign unused_hsync = i_hsync;

  assign frame_start = vsync_s1 & ~vsync_s1_q;
  assign tmo_hit     = (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
  assign restart_max = de_s1 ? dark_s1 : 8'd0;
  assign o_t_floor   = T0;
  assign o_state     = state;

  dehaze_weight_lut u_weight_lut (
    .dark_max (run_max),
    .weight   (table_weight)
  );

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      dark_s1    <= '0;
      de_s1      <= 1'b0;
      vsync_s1   <= 1'b0;
      vsync_s1_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so vsync_s1_q captures the pre-edge vsync_s1, giving a clean edge detect.
      dark_s1    <= i_dark;
      de_s1      <= i_de;
      vsync_s1   <= i_vsync;
      vsync_s1_q <= vsync_s1;
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      run_max       <= '0;
      tmo_cnt       <= '0;
      o_dark_max    <= '0;
      o_weight      <= '0;
      o_param_valid <= 1'b0;
      o_frame_done  <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_timeout    <= 1'b0;

      if (state != IDLE && de_s1 && dark_s1 > run_max) run_max <= dark_s1;

      unique case (state)
        IDLE: begin
          if (frame_start) begin
            state   <= ACCUM;
            run_max <= restart_max;
            tmo_cnt <= '0;
          end
        end
        ACCUM: begin
          if (frame_start) begin
            // Publish on the edge that opens LATCH; config is sampled here only.
            state        <= LATCH;
            run_max      <= restart_max;
            tmo_cnt      <= '0;
            o_frame_done <= 1'b1;
            if (!i_cfg_freeze) begin
              o_dark_max    <= run_max;
              o_weight      <= i_cfg_w_manual_en ? i_cfg_w_manual : table_weight;
              o_param_valid <= 1'b1;
            end
          end else if (tmo_hit) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            o_timeout     <= 1'b1;
            o_param_valid <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        LATCH:   state <= ACCUM;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dehaze_frame_ctrl.sv
// Self-checking bench for dehaze_frame_ctrl: a frame model pushes expected
// published parameters at each boundary; a monitor pops them on o_frame_done.
module tb_dehaze_frame_ctrl;

  logic       pixelclk = 1'b0;
  logic       reset_n;
  logic [7:0] i_dark;
  logic       i_hsync, i_vsync, i_de;
  logic       i_cfg_w_manual_en;
  logic [7:0] i_cfg_w_manual;
  logic       i_cfg_freeze;
  logic [7:0] o_dark_max, o_weight, o_t_floor;
  logic       o_param_valid, o_frame_done, o_timeout;
  logic [1:0] o_state;

  always #5 pixelclk = ~pixelclk;

  dehaze_frame_ctrl #(.TIMEOUT_CYCLES(24'd100)) dut (
    .pixelclk          (pixelclk),
    .reset_n           (reset_n),
    .i_dark            (i_dark),
    .i_hsync           (i_hsync),
    .i_vsync           (i_vsync),
    .i_de              (i_de),
    .i_cfg_w_manual_en (i_cfg_w_manual_en),
    .i_cfg_w_manual    (i_cfg_w_manual),
    .i_cfg_freeze      (i_cfg_freeze),
    .o_dark_max        (o_dark_max),
    .o_weight          (o_weight),
    .o_t_floor         (o_t_floor),
    .o_param_valid     (o_param_valid),
    .o_frame_done      (o_frame_done),
    .o_timeout         (o_timeout),
    .o_state           (o_state)
  );

  typedef struct packed {
    logic [7:0] dark;
    logic [7:0] weight;
    logic       valid;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_push   = 0;
  int   n_pop    = 0;
  int   k;
  bit   in_accum;
  logic [7:0] cur_max, pub_dark, pub_weight;
  logic       pub_valid;
  logic       done_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] table_w(input logic [7:0] m);
    if      (m <= 8'd160) return 8'd0;
    else if (m <= 8'd170) return 8'd255;
    else if (m <= 8'd180) return 8'd240;
    else if (m <= 8'd190) return 8'd224;
    else if (m <= 8'd200) return 8'd208;
    else if (m <= 8'd210) return 8'd200;
    else if (m <= 8'd220) return 8'd192;
    else if (m <= 8'd230) return 8'd184;
    else if (m <= 8'd240) return 8'd176;
    else                  return 8'd164;
  endfunction

  task automatic drive(input logic vs, input logic de, input logic [7:0] d);
    @(negedge pixelclk);
    i_vsync = vs;
    i_de    = de;
    i_dark  = d;
  endtask

  // Vsync rise closes the previous frame; the boundary pixel opens the new one.
  task automatic frame_start(input bit edge_de, input logic [7:0] edge_val);
    bit   expect_done;
    exp_t e;
    expect_done = in_accum;
    if (in_accum) begin
      if (!i_cfg_freeze) begin
        pub_dark   = cur_max;
        pub_weight = i_cfg_w_manual_en ? i_cfg_w_manual : table_w(cur_max);
        pub_valid  = 1'b1;
      end
      e.dark   = pub_dark;
      e.weight = pub_weight;
      e.valid  = pub_valid;
      sb.push_back(e);
      n_push++;
    end
    in_accum = 1'b1;
    cur_max  = edge_de ? edge_val : 8'd0;
    i_hsync  = 1'b0;
    drive(1'b1, edge_de, edge_de ? edge_val : 8'hFF);
    drive(1'b1, 1'b0, 8'hEE);
    check("done_early", o_frame_done, 0);
    drive(1'b0, 1'b0, 8'h00);
    check("done_latency", o_frame_done, expect_done);
    check("state_boundary", o_state, expect_done ? 2 : 1);
  endtask

  task automatic pixels(input logic [7:0] maxv, input int n, input bit use_de);
    for (int i = 0; i < n; i++) begin
      logic       de;
      logic [7:0] d;
      de = use_de && ((i == n / 2) || (i % 4 != 3));
      if (!de)               d = 8'($urandom_range(0, 255));
      else if (i == n / 2)   d = maxv;
      else if (maxv == 8'd0) d = 8'd0;
      else                   d = 8'($urandom_range(0, 32'(maxv) - 1));
      i_hsync = (i % 8 == 0);
      drive(1'b0, de, d);
      if (de && d > cur_max) cur_max = d;
    end
  endtask

  always @(negedge pixelclk) begin
    if (reset_n !== 1'b1) begin
      done_q = 1'b0;
    end else begin
      if (done_q) check("done_width", o_frame_done, 0);
      if (o_frame_done) begin
        if (sb.size() == 0) begin
          check("sb_spurious_done", o_frame_done, 0);
        end else begin
          mon_e = sb.pop_front();
          n_pop++;
          check("sb_dark_max", o_dark_max, mon_e.dark);
          check("sb_weight", o_weight, mon_e.weight);
          check("sb_param_valid", o_param_valid, mon_e.valid);
          check("t_floor", o_t_floor, 26);
        end
      end
      done_q = o_frame_done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    i_dark = '0; i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
    i_cfg_w_manual_en = 1'b0; i_cfg_w_manual = '0; i_cfg_freeze = 1'b0;
    in_accum = 1'b0; cur_max = '0; pub_dark = '0; pub_weight = '0; pub_valid = 1'b0;

    repeat (2) @(negedge pixelclk);
    check("rst_dark_max", o_dark_max, 0);
    check("rst_weight", o_weight, 0);
    check("rst_valid", o_param_valid, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_state", o_state, 0);
    check("rst_t_floor", o_t_floor, 26);
    @(negedge pixelclk) reset_n = 1'b1;
    repeat (3) @(negedge pixelclk);
    check("idle_state", o_state, 0);

    // Three frames 150/175/245, then table boundaries 160/161/240/241.
    frame_start(1'b0, 8'd0); pixels(8'd150, 30, 1'b1);
    check("state_accum", o_state, 1);
    frame_start(1'b0, 8'd0); pixels(8'd175, 30, 1'b1);
    check("valid_first", o_param_valid, 1);
    frame_start(1'b0, 8'd0); pixels(8'd245, 30, 1'b1);
    frame_start(1'b0, 8'd0); pixels(8'd160, 30, 1'b1);
    check("dark_f3", o_dark_max, 245);
    frame_start(1'b1, 8'd161); pixels(8'd100, 30, 1'b1);
    frame_start(1'b0, 8'd0); pixels(8'd240, 30, 1'b1);
    frame_start(1'b0, 8'd0); pixels(8'd241, 30, 1'b1);
    frame_start(1'b0, 8'd0);
    check("weight_241", o_weight, 164);
    pixels(8'd0, 30, 1'b0);
    frame_start(1'b0, 8'd0);
    check("nodata_dark", o_dark_max, 0);
    check("nodata_weight", o_weight, 0);

    // Manual weight enabled mid-frame applies only at the next boundary.
    pixels(8'd200, 15, 1'b1);
    i_cfg_w_manual = 8'd128; i_cfg_w_manual_en = 1'b1;
    pixels(8'd200, 15, 1'b1);
    check("weight_mid_manual", o_weight, 0);
    frame_start(1'b0, 8'd0);
    check("weight_manual", o_weight, 128);
    i_cfg_w_manual_en = 1'b0;
    pixels(8'd220, 20, 1'b1);
    frame_start(1'b0, 8'd0);

    // Freeze across a boundary.
    pixels(8'd185, 20, 1'b1);
    i_cfg_freeze = 1'b1;
    frame_start(1'b0, 8'd0);
    check("freeze_dark", o_dark_max, 220);
    pixels(8'd250, 20, 1'b1);
    i_cfg_freeze = 1'b0;
    frame_start(1'b0, 8'd0);

    // Asynchronous reset mid-frame.
    pixels(8'd90, 10, 1'b1);
    check("state_pre_reset", o_state, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_dark", o_dark_max, 0);
    check("mid_rst_weight", o_weight, 0);
    check("mid_rst_valid", o_param_valid, 0);
    check("mid_rst_done", o_frame_done, 0);
    check("mid_rst_timeout", o_timeout, 0);
    check("mid_rst_state", o_state, 0);
    in_accum = 1'b0; cur_max = '0; pub_dark = '0; pub_weight = '0; pub_valid = 1'b0;
    @(negedge pixelclk);
    @(negedge pixelclk) reset_n = 1'b1;
    frame_start(1'b0, 8'd0); pixels(8'd100, 20, 1'b1);
    frame_start(1'b0, 8'd0);

    // Loss of video: vsync stays low.
    for (k = 1; k <= 300; k++) begin
      @(negedge pixelclk);
      if (o_timeout) break;
    end
    check("timeout_seen", o_timeout, 1);
    check("timeout_latency", k, 101);
    check("timeout_valid", o_param_valid, 0);
    check("timeout_state", o_state, 0);
    check("timeout_hold_dark", o_dark_max, 100);
    in_accum = 1'b0; pub_valid = 1'b0;
    @(negedge pixelclk);
    check("timeout_width", o_timeout, 0);
    frame_start(1'b0, 8'd0); pixels(8'd230, 20, 1'b1);
    frame_start(1'b0, 8'd0);

    repeat (5) @(negedge pixelclk);
    check("sb_drain", sb.size(), 0);
    check("sb_push_pop", n_pop, n_push);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dehaze_frame_ctrl.md
DEHAZE_FRAME_CTRL -- requirements
Module: dehaze_frame_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd16777215: the number of cycles without a frame start before the block reports loss of video.
REQ-002 SHALL have parameter T0, default 8'd26: the transmittance floor forwarded to the datapath.
REQ-003 pixelclk  in  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_dark  in  8  dark-channel pixel.
REQ-006 i_hsync, i_vsync, i_de  in  1 each  video timing; i_vsync is active high.
REQ-007 i_cfg_w_manual_en  in  1  selects the manual haze weight instead of the table weight.
REQ-008 i_cfg_w_manual  in  8  manual weight (w*256).
REQ-009 i_cfg_freeze  in  1  holds the published parameters.
REQ-010 o_dark_max  out  8  atmospheric light A, the maximum of the last complete frame.
REQ-011 o_weight  out  8  haze weight w*256 for the next frame.
REQ-012 o_t_floor  out  8  equals T0.
REQ-013 o_param_valid  out  1  parameters reflect at least one complete frame.
REQ-014 o_frame_done  out  1  one-cycle pulse at each frame boundary.
REQ-015 o_timeout  out  1  one-cycle pulse on loss of video.
REQ-016 o_state  out  2  current FSM state, for debug.

Function
REQ-017 SHALL register i_dark, i_de and i_vsync once (stage S1); all decisions use S1 values.
REQ-018 SHALL detect a frame start as S1 vsync high while the previous S1 vsync was low.
REQ-019 FSM SHALL use states IDLE=0, ACCUM=1, LATCH=2. Transitions:
- IDLE->ACCUM on a frame start.
- ACCUM->LATCH on a frame start.
- LATCH->ACCUM unconditionally after one cycle.
- ACCUM->IDLE on timeout.
REQ-020 In ACCUM, SHALL update the running max to the S1 dark value whenever S1 de is high and that value is greater than the running max.
REQ-021 On a frame start (entering ACCUM or LATCH), SHALL copy the running max into a snapshot register and restart the running max at S1 dark if S1 de is high, else at 0; the pixel on the boundary cycle belongs to the new frame.
REQ-022 In LATCH, when i_cfg_freeze is 0, SHALL set o_dark_max to the snapshot, set o_weight per REQ-023/024, and set o_param_valid to 1.
REQ-023 Weight table (snapshot m, inclusive ranges):
- m<=160 -> 0
- 161-170 -> 255
- 171-180 -> 240
- 181-190 -> 224
- 191-200 -> 208
- 201-210 -> 200
- 211-220 -> 192
- 221-230 -> 184
- 231-240 -> 176
- 241-255 -> 164
REQ-024 If i_cfg_w_manual_en is sampled high in LATCH, SHALL use i_cfg_w_manual instead of the table value.
REQ-025 Configuration inputs SHALL be sampled only in LATCH; changes mid-frame take effect at the next boundary.
REQ-026 If i_cfg_freeze is 1 in LATCH, SHALL hold o_dark_max, o_weight and o_param_valid; o_frame_done still pulses.
REQ-027 SHALL pulse o_frame_done for exactly the LATCH cycle. The outputs update at the second pixelclk edge after the first i_vsync-high sample at the port (latency 2).
REQ-028 The first frame start from IDLE SHALL NOT enter LATCH or pulse o_frame_done, because the preceding frame is partial.
REQ-029 SHALL keep a 24-bit timeout counter that clears on every frame start and increments otherwise in ACCUM. When it reaches TIMEOUT_CYCLES, SHALL enter IDLE, pulse o_timeout, clear o_param_valid, and hold o_dark_max and o_weight.
REQ-030 A frame with no de pixels SHALL publish o_dark_max=0 and table weight 0.
REQ-031 o_t_floor SHALL be constant T0 in every state, including reset.

Reset
REQ-032 Asserting reset_n low SHALL immediately force:
- state IDLE
- o_dark_max=0, o_weight=0
- o_param_valid=0, o_frame_done=0, o_timeout=0
- running max, snapshot, timeout counter and S1 registers cleared
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; after release, the block waits for a new frame start.

Structure
REQ-034 A shared package dehaze_pkg SHALL hold the state encoding, the weight-table breakpoints and values, and the T0 default.
REQ-035 The weight table SHALL be a sub-module dehaze_weight_lut: 8-bit max in, 8-bit weight out, purely combinational.

Verification
REQ-036 Reset mid-frame: assert reset_n low during ACCUM -> all outputs 0, o_state=0 without waiting for a clock edge.
REQ-037 Three frames, pixel maxima 150/175/245 -> after frames 2 and 3, o_dark_max/o_weight = 175/240 then 245/164; o_param_valid=1 from the first LATCH.
REQ-038 Boundary: frame max exactly 160, 161, 240, 241 -> o_weight 0, 255, 176, 164.
REQ-039 i_cfg_w_manual_en=1 with i_cfg_w_manual=8'd128, toggled mid-frame -> o_weight=128 only from the next o_frame_done.
REQ-040 i_cfg_freeze=1 across a boundary -> outputs unchanged, o_frame_done still pulses one cycle.
REQ-041 TIMEOUT_CYCLES=100, vsync stopped -> o_timeout pulses after 100 cycles in ACCUM, o_param_valid=0, o_state=IDLE; the next frame start gives no o_frame_done.
